// File: rtl/des_cmd_sequencer_if.sv
// Command port between the job sequencer and a DES search block wrapper.
// master: drives cmd/cmd_valid/data; slave: returns cmd_read/done/counter.
interface des_cmd_sequencer_if;
    logic [31:0] cmd;
    logic        cmd_valid;
    logic [31:0] data_upper;
    logic [31:0] data_lower;
    logic        cmd_read;
    logic        done;
    logic [63:0] counter;

    modport master (
        output cmd, cmd_valid, data_upper, data_lower,
        input  cmd_read, done, counter
    );

    modport slave (
        input  cmd, cmd_valid, data_upper, data_lower,
        output cmd_read, done, counter
    );
endinterface

// File: rtl/des_cmd_sequencer.sv
// Runs one DES search job: RESTART, SEED, POLY, START, wait done, RESTART.
// Ports: clk/rst_n, job_*_i from CPU regs, job status _o, cmd_if to block.
module des_cmd_sequencer #(
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [63:0]          job_seed_i,
    input  logic [63:0]          job_poly_i,
    input  logic                 job_start_i,
    input  logic                 job_abort_i,
    output logic                 job_busy_o,
    output logic [63:0]          result_o,
    output logic                 result_valid_o,
    output logic                 timeout_err_o,
    des_cmd_sequencer_if.master  cmd_if
);

    localparam logic [31:0] CMD_SEED    = 32'd1;
    localparam logic [31:0] CMD_POLY    = 32'd2;
    localparam logic [31:0] CMD_START   = 32'd3;
    localparam logic [31:0] CMD_RESTART = 32'd5;

    localparam int TW = (TIMEOUT_CYCLES > 0) ?
                        $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [TW-1:0] TMO_LIM = TW'(TIMEOUT_CYCLES);

    typedef enum logic [3:0] {
        S_IDLE,
        S_RST0_REQ, S_RST0_REL,
        S_SEED_REQ, S_SEED_REL,
        S_POLY_REQ, S_POLY_REL,
        S_START_REQ, S_START_REL,
        S_RUN, S_CAPTURE,
        S_RST1_REQ, S_RST1_REL
    } state_e;

    state_e                 state_q, state_d;
    logic [SYNC_STAGES-1:0] cr_sync_q, dn_sync_q;
    logic [TW-1:0]          tmo_q, tmo_d;
    logic [31:0]            cmd_q, cmd_d;
    logic                   valid_q, valid_d;
    logic [31:0]            up_q, up_d;
    logic [31:0]            lo_q, lo_d;
    logic                   busy_q, busy_d;
    logic [63:0]            res_q, res_d;
    logic                   rv_q, rv_d;
    logic                   terr_q, terr_d;
    logic                   abort_q, abort_d;
    logic [63:0]            seed_q, seed_d;
    logic [63:0]            poly_q, poly_d;

    logic        cr_s, dn_s;
    logic        is_hs, tmo_hit;
    logic        req_go, to_idle, tmo_fire;
    logic [31:0] req_cmd;
    logic [63:0] req_dat;

    assign cr_s = cr_sync_q[SYNC_STAGES-1];
    assign dn_s = dn_sync_q[SYNC_STAGES-1];

    // Handshake wait states are the only ones the timeout watches.
    assign is_hs = (state_q != S_IDLE) && (state_q != S_RUN) &&
                   (state_q != S_CAPTURE);

    assign tmo_hit = (TIMEOUT_CYCLES != 0) &&
                     ((tmo_q + 1'b1) == TMO_LIM);

    always_comb begin
        state_d  = state_q;
        cmd_d    = cmd_q;
        valid_d  = valid_q;
        up_d     = up_q;
        lo_d     = lo_q;
        busy_d   = busy_q;
        res_d    = res_q;
        rv_d     = 1'b0;
        terr_d   = terr_q;
        abort_d  = abort_q | (busy_q & job_abort_i);
        seed_d   = seed_q;
        poly_d   = poly_q;
        req_go   = 1'b0;
        req_cmd  = '0;
        req_dat  = '0;
        to_idle  = 1'b0;
        tmo_fire = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (job_start_i) begin
                    seed_d  = job_seed_i;
                    poly_d  = job_poly_i;
                    terr_d  = 1'b0;
                    busy_d  = 1'b1;
                    state_d = S_RST0_REQ;
                    req_go  = 1'b1;
                    req_cmd = CMD_RESTART;
                end
            end
            // Every REQ state is followed by its REL state in the enum.
            S_RST0_REQ, S_SEED_REQ, S_POLY_REQ,
            S_START_REQ, S_RST1_REQ: begin
                if (cr_s) begin
                    valid_d = 1'b0;
                    state_d = state_e'(state_q + 4'd1);
                end else if (tmo_hit) begin
                    tmo_fire = 1'b1;
                end
            end
            S_RST0_REL: begin
                if (!cr_s) begin
                    state_d = S_SEED_REQ;
                    req_go  = 1'b1;
                    req_cmd = CMD_SEED;
                    req_dat = seed_q;
                end else if (tmo_hit) begin
                    tmo_fire = 1'b1;
                end
            end
            S_SEED_REL: begin
                if (!cr_s) begin
                    state_d = S_POLY_REQ;
                    req_go  = 1'b1;
                    req_cmd = CMD_POLY;
                    req_dat = poly_q;
                end else if (tmo_hit) begin
                    tmo_fire = 1'b1;
                end
            end
            S_POLY_REL: begin
                if (!cr_s) begin
                    state_d = S_START_REQ;
                    req_go  = 1'b1;
                    req_cmd = CMD_START;
                end else if (tmo_hit) begin
                    tmo_fire = 1'b1;
                end
            end
            S_START_REL: begin
                if (!cr_s) begin
                    state_d = S_RUN;
                    cmd_d   = '0;
                end else if (tmo_hit) begin
                    tmo_fire = 1'b1;
                end
            end
            S_RUN: begin
                // done has priority over a pending abort
                if (dn_s) begin
                    state_d = S_CAPTURE;
                end else if (abort_q) begin
                    state_d = S_RST1_REQ;
                    req_go  = 1'b1;
                    req_cmd = CMD_RESTART;
                end
            end
            S_CAPTURE: begin
                res_d   = cmd_if.counter;
                rv_d    = 1'b1;
                state_d = S_RST1_REQ;
                req_go  = 1'b1;
                req_cmd = CMD_RESTART;
            end
            S_RST1_REL: begin
                if (!cr_s) begin
                    to_idle = 1'b1;
                end else if (tmo_hit) begin
                    tmo_fire = 1'b1;
                end
            end
            default: to_idle = 1'b1;
        endcase

        if (req_go) begin
            cmd_d   = req_cmd;
            valid_d = 1'b1;
            up_d    = req_dat[63:32];
            lo_d    = req_dat[31:0];
        end
        if (tmo_fire) begin
            to_idle = 1'b1;
            terr_d  = 1'b1;
        end
        if (to_idle) begin
            state_d = S_IDLE;
            cmd_d   = '0;
            valid_d = 1'b0;
            up_d    = '0;
            lo_d    = '0;
            busy_d  = 1'b0;
            abort_d = 1'b0;
        end
    end

    // Reload on any state change; saturate so the count never wraps.
    always_comb begin
        tmo_d = tmo_q;
        if (state_d != state_q) begin
            tmo_d = '0;
        end else if (is_hs && (tmo_q != TMO_LIM)) begin
            tmo_d = tmo_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cr_sync_q <= '0;
            dn_sync_q <= '0;
            tmo_q     <= '0;
            cmd_q     <= '0;
            valid_q   <= 1'b0;
            up_q      <= '0;
            lo_q      <= '0;
            busy_q    <= 1'b0;
            res_q     <= '0;
            rv_q      <= 1'b0;
            terr_q    <= 1'b0;
            abort_q   <= 1'b0;
            seed_q    <= '0;
            poly_q    <= '0;
        end else begin
            state_q   <= state_d;
            cr_sync_q <= (cr_sync_q << 1) |
                         SYNC_STAGES'(cmd_if.cmd_read);
            dn_sync_q <= (dn_sync_q << 1) |
                         SYNC_STAGES'(cmd_if.done);
            tmo_q     <= tmo_d;
            cmd_q     <= cmd_d;
            valid_q   <= valid_d;
            up_q      <= up_d;
            lo_q      <= lo_d;
            busy_q    <= busy_d;
            res_q     <= res_d;
            rv_q      <= rv_d;
            terr_q    <= terr_d;
            abort_q   <= abort_d;
            seed_q    <= seed_d;
            poly_q    <= poly_d;
        end
    end

    assign cmd_if.cmd        = cmd_q;
    assign cmd_if.cmd_valid  = valid_q;
    assign cmd_if.data_upper = up_q;
    assign cmd_if.data_lower = lo_q;
    assign job_busy_o        = busy_q;
    assign result_o          = res_q;
    assign result_valid_o    = rv_q;
    assign timeout_err_o     = terr_q;

endmodule
